// File: rtl/simon_pkg.sv
// Shared types, constants and helper functions for the parameterised Simon core.
// Z_SEQ literals are written first-bit-leftmost, so bit c of a sequence is Z_SEQ[j][61-c].
package simon_pkg;

   typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} state_e;

   localparam logic [61:0] Z_SEQ [5] = '{
      62'b11111010001001010110000111001101111101000100101011000011100110,
      62'b10001110111110010011000010110101000111011111001001100001011010,
      62'b10101111011100000011010010011000101000010001111110010110110011,
      62'b11011011101011000110010111100000010010001010011100110100001111,
      62'b11010001111001101011011000100000010111000011001010010011101111
   };

   // Round count T for word size n and key words m.
   function automatic int unsigned rounds(input int unsigned n, input int unsigned m);
      int unsigned t;
      t = 68;
      if (n == 32) begin
         t = (m == 3) ? 42 : 44;
      end else begin
         if (m == 3) t = 69;
         else if (m == 4) t = 72;
      end
      return t;
   endfunction

   // z-sequence index j for word size n and key words m.
   function automatic int unsigned zidx(input int unsigned n, input int unsigned m);
      int unsigned j;
      j = 2;
      if (n == 32) begin
         j = (m == 3) ? 2 : 3;
      end else begin
         if (m == 3) j = 3;
         else if (m == 4) j = 4;
      end
      return j;
   endfunction

   // Rotate left by s within the low n bits; x must already be confined to n bits.
   function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n,
                                        input int unsigned s);
      logic [63:0] mask;
      mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
      return ((x << s) | (x >> (n - s))) & mask;
   endfunction

   // Simon mixing function on an n-bit word held in the low bits of x.
   function automatic logic [63:0] simon_f(input logic [63:0] x, input int unsigned n);
      return (rotl(x, n, 1) & rotl(x, n, 8)) ^ rotl(x, n, 2);
   endfunction

endpackage

// File: rtl/simon_key_sched.sv
// Simon key schedule: m-word shift register, one new round key per step.
// k_o is the current round key (word 0); load_i restarts the z-sequence counter.
module simon_key_sched import simon_pkg::*; #(
   parameter int unsigned N = 64,
   parameter int unsigned M = 2,
   parameter int unsigned J = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_i,
   input  logic           step_i,
   input  logic [N*M-1:0] key_i,
   output logic [N-1:0]   k_o
);

   localparam logic [61:0] ZJ = Z_SEQ[J];

   logic [N-1:0] k_q [M];
   logic [N-1:0] k_d [M];
   logic [5:0]   c_q, c_d;
   logic [N-1:0] tmp;
   logic [N-1:0] new_w;
   logic         z_bit;

   assign k_o = k_q[0];

   // Next key word from the top word (and word 1 for four-word keys).
   always_comb begin
      tmp = {k_q[M-1][2:0], k_q[M-1][N-1:3]};
      if (M == 4) tmp = tmp ^ k_q[1];
      tmp   = tmp ^ {tmp[0], tmp[N-1:1]};
      z_bit = ZJ[6'd61 - c_q];
      new_w = ~k_q[0] ^ tmp ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);
   end

   // Load a fresh key or shift down and append the new word.
   always_comb begin
      for (int i = 0; i < M; i++) k_d[i] = k_q[i];
      c_d = c_q;
      if (load_i) begin
         for (int i = 0; i < M; i++) k_d[i] = key_i[i*N +: N];
         c_d = '0;
      end else if (step_i) begin
         for (int i = 0; i < M - 1; i++) k_d[i] = k_q[i+1];
         k_d[M-1] = new_w;
         c_d      = (c_q == 6'd61) ? '0 : c_q + 6'd1;
      end
   end

   // Key word and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < M; i++) k_q[i] <= '0;
         c_q <= '0;
      end else begin
         for (int i = 0; i < M; i++) k_q[i] <= k_d[i];
         c_q <= c_d;
      end
   end

endmodule

// File: rtl/simon_core_param.sv
// Iterative Simon block cipher, one round per clock, valid/ready on both sides.
// Build option SIMON_DECRYPT_EN adds a stored round-key array and decryption (mode_i=1).
module simon_core_param import simon_pkg::*; #(
   parameter int unsigned BLOCK_W = 128,
   parameter int unsigned KEY_W   = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic               mode_i,
   input  logic [BLOCK_W-1:0] data_i,
   input  logic [KEY_W-1:0]   key_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [BLOCK_W-1:0] data_o,
   output logic               busy_o
);

   localparam int unsigned N       = BLOCK_W / 2;
   localparam int unsigned M       = KEY_W / N;
   localparam int unsigned T       = rounds(N, M);
   localparam int unsigned J       = zidx(N, M);
   localparam logic [6:0]  LastCnt = 7'(T - 1);

   if (!((BLOCK_W == 64 && (KEY_W == 96 || KEY_W == 128)) ||
         (BLOCK_W == 128 && (KEY_W == 128 || KEY_W == 192 || KEY_W == 256)))) begin : g_bad_cfg
      $error("simon_core_param: unsupported BLOCK_W/KEY_W %0d/%0d", BLOCK_W, KEY_W);
   end

   state_e             state_q, state_d;
   logic [6:0]         cnt_q, cnt_d;
   logic [N-1:0]       x_q, x_d, y_q, y_d;
   logic [BLOCK_W-1:0] dout_q, dout_d;
   logic               ovalid_q, ovalid_d;
   logic               accept;
   logic               sched_step;
   logic [N-1:0]       sched_k;
   logic [N-1:0]       rk;
   logic [N-1:0]       rnd_x, rnd_y;
   logic [63:0]        x_ext, fx_ext;

   assign accept      = in_valid_i && (state_q == IDLE);
   assign in_ready_o  = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign out_valid_o = ovalid_q;
   assign data_o      = dout_q;

   simon_key_sched #(
      .N (N),
      .M (M),
      .J (J)
   ) u_key_sched (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .step_i (sched_step),
      .key_i  (key_i),
      .k_o    (sched_k)
   );

   // Widen x for the shared mixing function.
   always_comb begin
      x_ext          = '0;
      x_ext[N-1:0]   = x_q;
      fx_ext         = simon_f(x_ext, N);
   end

`ifdef SIMON_DECRYPT_EN
   logic         mode_q, mode_d;
   logic [N-1:0] key_arr_q [T];
   logic [6:0]   ridx;
   logic [63:0]  y_ext, fy_ext;

   assign ridx       = LastCnt - cnt_q;
   assign rk         = mode_q ? key_arr_q[ridx] : sched_k;
   // Decrypt reads stored keys, so the schedule only advances for KEYEXP or encrypt.
   assign sched_step = (state_q == KEYEXP) || (state_q == RUN && !mode_q);

   // Widen y for the inverse round.
   always_comb begin
      y_ext        = '0;
      y_ext[N-1:0] = y_q;
      fy_ext       = simon_f(y_ext, N);
   end

   // Capture each generated round key at its round index.
   always_ff @(posedge clk) begin
      if (sched_step) key_arr_q[cnt_q] <= sched_k;
   end
`else
   logic unused_mode;
   // mode_i has no function without decrypt support.
   assign unused_mode = mode_i;
   assign rk          = sched_k;
   assign sched_step  = (state_q == RUN);
`endif

   // One Simon round, forward or inverse.
   always_comb begin
      rnd_x = y_q ^ fx_ext[N-1:0] ^ rk;
      rnd_y = x_q;
`ifdef SIMON_DECRYPT_EN
      if (mode_q) begin
         rnd_x = y_q;
         rnd_y = x_q ^ fy_ext[N-1:0] ^ rk;
      end
`endif
   end

   // FSM next state, round counter and datapath updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      dout_d   = dout_q;
      ovalid_d = ovalid_q;
`ifdef SIMON_DECRYPT_EN
      mode_d   = mode_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               x_d   = data_i[BLOCK_W-1:N];
               y_d   = data_i[N-1:0];
               cnt_d = '0;
`ifdef SIMON_DECRYPT_EN
               mode_d  = mode_i;
               state_d = mode_i ? KEYEXP : RUN;
`else
               state_d = RUN;
`endif
            end
         end
         KEYEXP: begin
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == LastCnt) begin
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            x_d   = rnd_x;
            y_d   = rnd_y;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == LastCnt) begin
               cnt_d    = '0;
               state_d  = DONE;
               ovalid_d = 1'b1;
               dout_d   = {rnd_x, rnd_y};
            end
         end
         DONE: begin
            if (out_ready_i) begin
               ovalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         dout_q   <= '0;
         ovalid_q <= 1'b0;
`ifdef SIMON_DECRYPT_EN
         mode_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dout_q   <= dout_d;
         ovalid_q <= ovalid_d;
`ifdef SIMON_DECRYPT_EN
         mode_q   <= mode_d;
`endif
      end
   end

endmodule

// File: tb/tb_simon_core_param.sv
// Directed bench for simon_core_param: 128/128 instance (a_*) and 64/128 instance (b_*).
module tb_simon_core_param;

   localparam logic [127:0] KEY128 = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] PT128  = 128'h6373656420737265_6c6c657661727420;
   localparam logic [127:0] CT128  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
   localparam logic [127:0] KEY64  = 128'h1b1a1918_13121110_0b0a0908_03020100;
   localparam logic [63:0]  PT64   = 64'h656b696c_20646e75;
   localparam logic [63:0]  CT64   = 64'h44c8fc20_b9dfa07a;

   int n_pass  = 0;
   int n_total = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_busy;
   logic [127:0] a_data_i, a_key, a_data_o;
   logic         b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_busy;
   logic [63:0]  b_data_i, b_data_o;
   logic [127:0] b_key;

   simon_core_param #(
      .BLOCK_W (128),
      .KEY_W   (128)
   ) u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (a_in_valid),
      .in_ready_o  (a_in_ready),
      .mode_i      (a_mode),
      .data_i      (a_data_i),
      .key_i       (a_key),
      .out_valid_o (a_out_valid),
      .out_ready_i (a_out_ready),
      .data_o      (a_data_o),
      .busy_o      (a_busy)
   );

   simon_core_param #(
      .BLOCK_W (64),
      .KEY_W   (128)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (b_in_valid),
      .in_ready_o  (b_in_ready),
      .mode_i      (b_mode),
      .data_i      (b_data_i),
      .key_i       (b_key),
      .out_valid_o (b_out_valid),
      .out_ready_i (b_out_ready),
      .data_o      (b_data_o),
      .busy_o      (b_busy)
   );

   task automatic wait_a(output logic [127:0] res, output int lat);
      lat = 0;
      while (!a_out_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
      res = a_data_o;
   endtask

   // Present one request, scramble inputs after the accept edge, wait for the result.
   task automatic run_a(input logic [127:0] pt, input logic [127:0] key, input logic mode,
                        output logic [127:0] res, output int lat);
      a_data_i   = pt;
      a_key      = key;
      a_mode     = mode;
      a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_data_i   = '1;
      a_key      = '1;
      a_mode     = ~mode;
      wait_a(res, lat);
   endtask

   task automatic hs_a();
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_mode = 1'b0; a_data_i = '0; a_key = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_mode = 1'b0; b_data_i = '0; b_key = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_total++;
      if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
      else n_pass++;
      n_total++;
      if (a_data_o !== 128'h0) $display("FAIL reset_data_o: got %h want 0", a_data_o);
      else n_pass++;
      n_total++;
      if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy);
      else n_pass++;
      n_total++;
      if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
      else n_pass++;
      n_total++;
      if ({b_in_ready, b_out_valid, b_data_o} !== {1'b1, 1'b0, 64'h0})
         $display("FAIL reset_b: got rdy=%b vld=%b data=%h want 1 0 0",
                  b_in_ready, b_out_valid, b_data_o);
      else n_pass++;
   endtask

   task automatic test_enc128();
      logic [127:0] res;
      int lat;
      run_a(PT128, KEY128, 1'b0, res, lat);
      n_total++;
      if (lat !== 68) $display("FAIL enc128_latency: got %0d want 68", lat);
      else n_pass++;
      n_total++;
      if (res !== CT128) $display("FAIL enc128_data: got %h want %h", res, CT128);
      else n_pass++;
      hs_a();
      n_total++;
      if ({a_in_ready, a_out_valid} !== 2'b10)
         $display("FAIL enc128_after_hs: got rdy=%b vld=%b want 1 0", a_in_ready, a_out_valid);
      else n_pass++;
   endtask

   task automatic test_enc64();
      int lat;
      b_data_i   = PT64;
      b_key      = KEY64;
      b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_data_i   = '1;
      b_key      = '1;
      lat = 0;
      while (!b_out_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
      n_total++;
      if (lat !== 44) $display("FAIL enc64_latency: got %0d want 44", lat);
      else n_pass++;
      n_total++;
      if (b_data_o !== CT64) $display("FAIL enc64_data: got %h want %h", b_data_o, CT64);
      else n_pass++;
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      n_total++;
      if (b_in_ready !== 1'b1) $display("FAIL enc64_after_hs: got %b want 1", b_in_ready);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [127:0] res;
      int lat;
      run_a(PT128, KEY128, 1'b0, res, lat);
      n_total++;
      if (res !== CT128) $display("FAIL bp_data: got %h want %h", res, CT128);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         a_in_valid = 1'b1;
         a_data_i   = PT128 ^ 128'(i + 1);
         a_key      = KEY128;
         @(posedge clk); #1;
         n_total++;
         if ({a_data_o, a_in_ready, a_out_valid, a_busy} !== {CT128, 1'b0, 1'b1, 1'b1})
            $display("FAIL bp_hold_%0d: got data=%h rdy=%b vld=%b busy=%b want %h 0 1 1",
                     i, a_data_o, a_in_ready, a_out_valid, a_busy, CT128);
         else n_pass++;
      end
      a_in_valid = 1'b0;
      hs_a();
      n_total++;
      if ({a_in_ready, a_out_valid, a_busy} !== 3'b100)
         $display("FAIL bp_release: got rdy=%b vld=%b busy=%b want 1 0 0",
                  a_in_ready, a_out_valid, a_busy);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (a_busy !== 1'b0) $display("FAIL bp_no_extra_accept: got busy=%b want 0", a_busy);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] res;
      int lat;
      run_a(PT128, KEY128, 1'b0, res, lat);
      n_total++;
      if (res !== CT128) $display("FAIL b2b_first: got %h want %h", res, CT128);
      else n_pass++;
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_data_i    = PT128;
      a_key       = KEY128;
      a_mode      = 1'b0;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      n_total++;
      if ({a_in_ready, a_busy} !== 2'b10)
         $display("FAIL b2b_no_same_cycle: got rdy=%b busy=%b want 1 0", a_in_ready, a_busy);
      else n_pass++;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_data_i   = '0;
      a_key      = '0;
      n_total++;
      if (a_busy !== 1'b1) $display("FAIL b2b_second_accept: got busy=%b want 1", a_busy);
      else n_pass++;
      wait_a(res, lat);
      n_total++;
      if (lat !== 68 || res !== CT128)
         $display("FAIL b2b_second: got lat=%0d data=%h want 68 %h", lat, res, CT128);
      else n_pass++;
      hs_a();
   endtask

   task automatic test_reset_mid();
      logic [127:0] res;
      int lat;
      a_data_i   = PT128;
      a_key      = KEY128;
      a_mode     = 1'b0;
      a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_total++;
      if ({a_out_valid, a_in_ready, a_busy} !== 3'b010)
         $display("FAIL midrst_ctrl: got vld=%b rdy=%b busy=%b want 0 1 0",
                  a_out_valid, a_in_ready, a_busy);
      else n_pass++;
      n_total++;
      if (a_data_o !== 128'h0) $display("FAIL midrst_data_o: got %h want 0", a_data_o);
      else n_pass++;
      run_a(PT128, KEY128, 1'b0, res, lat);
      n_total++;
      if (lat !== 68 || res !== CT128)
         $display("FAIL midrst_rerun: got lat=%0d data=%h want 68 %h", lat, res, CT128);
      else n_pass++;
      hs_a();
   endtask

   task automatic test_mode();
      logic [127:0] res;
      int lat;
`ifdef SIMON_DECRYPT_EN
      run_a(CT128, KEY128, 1'b1, res, lat);
      n_total++;
      if (lat !== 136) $display("FAIL dec_latency: got %0d want 136", lat);
      else n_pass++;
      n_total++;
      if (res !== PT128) $display("FAIL dec_data: got %h want %h", res, PT128);
      else n_pass++;
      hs_a();
      run_a(PT128, KEY128, 1'b0, res, lat);
      n_total++;
      if (lat !== 68 || res !== CT128)
         $display("FAIL enc_after_dec: got lat=%0d data=%h want 68 %h", lat, res, CT128);
      else n_pass++;
      hs_a();
`else
      run_a(PT128, KEY128, 1'b1, res, lat);
      n_total++;
      if (lat !== 68) $display("FAIL mode_ignored_latency: got %0d want 68", lat);
      else n_pass++;
      n_total++;
      if (res !== CT128) $display("FAIL mode_ignored_data: got %h want %h", res, CT128);
      else n_pass++;
      hs_a();
`endif
   endtask

   initial begin
      test_reset();
      test_enc128();
      test_enc64();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_mode();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
